spi_target: RTL and testbench
=============================

# spi_target

Memory-mapped SPI target (peripheral-side) controller: the responder end of the SPI links driven by the SoC's SPI master. It lets the on-chip CPU act as an SPI device to an external host. The block samples an externally driven SCLK/CS_n/MOSI in the system clock domain, shifts received bytes into a one-byte RX holding register, and shifts a CPU-supplied byte out on MISO. It sits on the same native `mem_*` bus as the other MMIO peripherals, with the same `ready`/`sel` stall convention.

## Interface
- `ADDR`, default 32'hffff_fff8, base address: data register at ADDR, status register at ADDR+4.
- `clk`  in  1  system clock; single clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `spi_sclk`  in  1  external SPI clock, mode 0 (CPOL=0, CPHA=0).
- `spi_cs_n`  in  1  external chip select, active low.
- `spi_mosi`  in  1  serial data from host, MSB first.
- `spi_miso`  out  1  serial data to host, MSB first.
- `mem_valid`, `mem_addr[31:0]`, `mem_wdata[31:0]`, `mem_wstrb[3:0]`  in  CPU bus request.
- `spi_ready`  out  1  request completes this cycle.
- `spi_sel`  out  1  `mem_valid` and address is ADDR or ADDR+4.
- `spi_rdata`  out  32  read data, valid when `spi_ready` is high.

## Operation
- Input sync: `spi_sclk`, `spi_cs_n`, `spi_mosi` each pass through 2-flop synchronizers (reset values 0, 1, 0). An edge detector on synced SCLK yields one-cycle `rise`/`fall` pulses.
- FSM `IDLE` -> `ACTIVE` on synced CS_n 1->0.
  - On entry: `bit_cnt`=0. Load `tx_shift` from `tx_buf` if `tx_full` (clear `tx_full`), else load 8'hFF as idle fill.
- `ACTIVE`, on `rise`:
  - `rx_shift` <= {`rx_shift[6:0]`, mosi}, `bit_cnt`++ (3-bit, wraps 7->0).
  - On the 8th rise (`bit_cnt`==7): `rx_data` <= completed byte and `rx_has_data` <= 1.
  - If `rx_has_data` was already 1, also set `overrun` <= 1. The new byte overwrites the old one.
- `ACTIVE`, on `fall`: if `bit_cnt`==0 (byte boundary), reload `tx_shift` from `tx_buf`/idle fill as on entry; else `tx_shift` <= {`tx_shift[6:0]`, 1'b1}.
- `ACTIVE` -> `IDLE` on synced CS_n 0->1, including mid-byte. The partial RX byte is discarded and `bit_cnt`=0. A TX byte already loaded is consumed, not restored.
- `spi_miso` = `tx_shift[7]` in `ACTIVE`; 0 in `IDLE`.
- Data read (ADDR, wstrb=0):
  - If `rx_has_data`: `spi_ready`=1, `spi_rdata`={24'h0, `rx_data`}, and `rx_has_data` is cleared. If a byte completes in the same cycle, the new byte is stored and `rx_has_data` stays 1.
  - If `rx_has_data` is 0, the read stalls (`spi_ready`=0).
- Data write (ADDR, wstrb[0]):
  - If `!tx_full`: `spi_ready`=1, `tx_buf` <= wdata[7:0], `tx_full` <= 1.
  - If `tx_full`, the write stalls.
  - Same-cycle load by the shifter and CPU write: the shifter takes the old `tx_buf` and the write stalls that cycle.
- Status read (ADDR+4): always ready, returns {28'h0, active, overrun, tx_full, rx_has_data}.
- Status write (ADDR+4, wstrb[0]): always ready; wdata[2]=1 clears `overrun`. A same-cycle new overrun takes priority, so `overrun` stays 1.
- Unselected or other-strobe accesses: `spi_ready`=0, no state change.

## Timing
- Reset values:
  - Outputs: `spi_miso`=0, `spi_ready`=0, `spi_rdata`=0.
  - Internal: FSM `IDLE`, `rx_data`=0, `tx_buf`=0, `tx_shift`=8'hFF, all flags 0.
- `spi_ready`/`spi_rdata`/`spi_sel` are combinational from bus inputs and registered state; zero-wait when not stalled.
- SCLK high and low phases are each ≥4 `clk` periods. CS_n falling edge is ≥4 `clk` before the first SCLK rise.
- Edge-to-action latency is 3 `clk` (2 sync + 1 edge-detect register). `rx_has_data` rises 3 `clk` after the 8th external SCLK rise. MISO changes 3–4 `clk` after an SCLK fall, or after a CS_n fall.
- Reset asserted mid-transfer aborts it immediately. The next transfer starts only on a fresh synced CS_n falling edge.

## Structure
- Package `spi_pkg`: register offsets (DATA=0, STATUS=4), status bit indices, `IDLE_FILL`=8'hFF, FSM state enum.
- Sub-module `sync2`: 2-flop synchronizer with a reset-value parameter, instantiated 3×.

## Test plan
- Preload: CPU writes 8'hA5, then the host clocks one byte 8'h3C with CS low -> MISO shifts 1010_0101; CPU read returns 32'h0000_003C; status reads 4'b0000 after CS high.
- No preload -> MISO shifts 8'hFF; a CPU read issued before the byte completes stalls and completes 3 `clk` after the 8th SCLK rise.
- Two bytes 8'h11, 8'h22 with no CPU read -> data reads 8'h22, status shows overrun=1. Status write with wdata=32'h4 -> overrun=0.
- Write 8'h01 then 8'h02 with no SPI activity -> the second write stalls until CS falls and the shifter loads 8'h01, then completes and `tx_full`=1.
- CS deasserted after 5 bits -> `rx_has_data` stays 0. The next full byte 8'h80 is received correctly, with `bit_cnt` realigned.
- `resetn` pulsed low mid-byte -> outputs are immediately at reset values and status reads 0.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: register map, status bit positions and FSM states for spi_target
package spi_pkg;
  localparam logic [31:0] DATA_OFF = 32'd0;
  localparam logic [31:0] STATUS_OFF = 32'd4;
  localparam int ST_RX = 0;
  localparam int ST_TX = 1;
  localparam int ST_OVR = 2;
  localparam int ST_ACT = 3;
  localparam logic [7:0] IDLE_FILL = 8'hFF;
  typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/spi_target_sync2.sv
// sync2: two-flop synchronizer with a configurable reset value
module sync2 #(
  parameter logic RST = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic m;
  // shift the async input through two flops
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {q, m} <= {RST, RST};
    else {q, m} <= {m, d};
endmodule

// File: rtl/spi_target.sv
// spi_target: memory-mapped SPI mode-0 target with one-byte RX/TX holding registers
module spi_target
  import spi_pkg::*;
#(
  parameter logic [31:0] ADDR = 32'hffff_fff8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        spi_ready,
  output logic        spi_sel,
  output logic [31:0] spi_rdata
);
  logic sclk_s, cs_s, mosi_s, sclk_q, cs_q;
  logic rise, fall, cs_fall, cs_rise, active, load, byte_done;
  logic sel_data, sel_stat, rd_ok, wr_ok, st_rd, st_wr;
  state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, rx_data, tx_buf, tx_shift;
  logic rx_has_data, tx_full, overrun;
  logic [3:0] status;
  logic unused_wdata;

  sync2 #(.RST(1'b0)) u_sync_sclk (.clk(clk), .resetn(resetn), .d(spi_sclk), .q(sclk_s));
  sync2 #(.RST(1'b1)) u_sync_cs   (.clk(clk), .resetn(resetn), .d(spi_cs_n), .q(cs_s));
  sync2 #(.RST(1'b0)) u_sync_mosi (.clk(clk), .resetn(resetn), .d(spi_mosi), .q(mosi_s));

  assign rise = sclk_s & ~sclk_q;
  assign fall = ~sclk_s & sclk_q;
  assign cs_fall = cs_q & ~cs_s;
  assign cs_rise = ~cs_q & cs_s;
  assign active = state == ACTIVE;
  // the shifter loads a fresh byte at frame start and at every byte boundary fall
  assign load = active ? (!cs_rise && fall && bit_cnt == 3'd0) : cs_fall;
  assign byte_done = active && !cs_rise && rise && bit_cnt == 3'd7;
  assign spi_miso = active ? tx_shift[7] : 1'b0;

  assign sel_data = mem_valid && mem_addr == ADDR + DATA_OFF;
  assign sel_stat = mem_valid && mem_addr == ADDR + STATUS_OFF;
  assign spi_sel = sel_data || sel_stat;
  assign rd_ok = sel_data && mem_wstrb == 4'd0 && rx_has_data;
  // a write colliding with a shifter load stalls so the shifter sees the old buffer
  assign wr_ok = sel_data && mem_wstrb[0] && !tx_full && !load;
  assign st_rd = sel_stat && mem_wstrb == 4'd0;
  assign st_wr = sel_stat && mem_wstrb[0];
  assign spi_ready = rd_ok || wr_ok || st_rd || st_wr;
  assign status = {active, overrun, tx_full, rx_has_data};
  assign spi_rdata = rd_ok ? {24'h0, rx_data} : st_rd ? {28'h0, status} : 32'h0;
  assign unused_wdata = ^mem_wdata[31:8];

  // edge history, frame FSM and the RX/TX shift registers
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sclk_q <= 1'b0;
      cs_q <= 1'b1;
      state <= IDLE;
      bit_cnt <= 3'd0;
      rx_shift <= 8'h0;
      tx_shift <= IDLE_FILL;
    end else begin
      sclk_q <= sclk_s;
      cs_q <= cs_s;
      if (!active) begin
        if (cs_fall) begin
          state <= ACTIVE;
          bit_cnt <= 3'd0;
        end
      end else if (cs_rise) begin
        state <= IDLE;
        bit_cnt <= 3'd0;
      end else begin
        if (rise) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (fall && bit_cnt != 3'd0) tx_shift <= {tx_shift[6:0], 1'b1};
      end
      if (load) tx_shift <= tx_full ? tx_buf : IDLE_FILL;
    end

  // CPU-visible holding registers and flags; new SPI events win over CPU clears
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rx_data <= 8'h0;
      rx_has_data <= 1'b0;
      tx_buf <= 8'h0;
      tx_full <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (byte_done) rx_data <= {rx_shift[6:0], mosi_s};
      rx_has_data <= byte_done ? 1'b1 : rd_ok ? 1'b0 : rx_has_data;
      if (wr_ok) tx_buf <= mem_wdata[7:0];
      tx_full <= load ? 1'b0 : wr_ok ? 1'b1 : tx_full;
      overrun <= (byte_done && rx_has_data) ? 1'b1 : (st_wr && mem_wdata[ST_OVR]) ? 1'b0 : overrun;
    end
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed and randomized checks of spi_target against a byte-level model
module tb_spi_target;
  localparam logic [31:0] A_D = 32'hffff_fff8;
  localparam logic [31:0] A_S = 32'hffff_fffc;
  localparam int H = 6;

  logic clk = 1'b0, resetn = 1'b0;
  logic spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0, spi_miso;
  logic mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
  logic [3:0] mem_wstrb = 4'h0;
  logic spi_ready, spi_sel;
  logic [31:0] spi_rdata;
  int cyc = 0, rise8 = 0, ncmp = 0, nerr = 0;

  spi_target dut (
    .clk(clk), .resetn(resetn), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .spi_ready(spi_ready), .spi_sel(spi_sel), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] got);
    got = 8'h0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = d[7-i];
      tick(H);
      got[7-i] = spi_miso;
      spi_sclk = 1'b1;
      if (i == 7) rise8 = cyc;
      tick(H);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low;
    spi_cs_n = 1'b0;
    tick(H);
  endtask

  task automatic cs_high;
    tick(H);
    spi_cs_n = 1'b1;
    tick(H);
  endtask

  task automatic cpu_acc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                         input int lim, output logic [31:0] rd, output int waited,
                         output logic ok, output int rcyc);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr = a;
    mem_wdata = wd;
    mem_wstrb = st;
    waited = 0;
    #1;
    while (!spi_ready && waited < lim) begin
      @(negedge clk);
      #1;
      waited++;
    end
    ok = spi_ready;
    rd = spi_rdata;
    rcyc = cyc;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  initial begin
    logic [31:0] rd, rd2;
    logic [7:0] got, d;
    logic ok, ok2;
    int w, w2, rc;
    logic m_tx_full, m_has, m_ovr;
    logic [7:0] m_tx, m_rx, exp_tx;
    int nb;

    tick(3);
    chk("rst_miso", {31'h0, spi_miso}, 32'h0);
    chk("rst_ready", {31'h0, spi_ready}, 32'h0);
    chk("rst_rdata", spi_rdata, 32'h0);
    resetn = 1'b1;
    tick(2);
    cpu_acc(A_S, 0, 4'h0, 5, rd, w, ok, rc);
    chk("rst_status", rd, 32'h0);

    mem_valid = 1'b1;
    mem_addr = A_D + 32'd8;
    #1;
    chk("off_sel", {31'h0, spi_sel}, 32'h0);
    chk("off_ready", {31'h0, spi_ready}, 32'h0);
    mem_addr = A_S;
    #1;
    chk("stat_sel", {31'h0, spi_sel}, 32'h1);
    mem_valid = 1'b0;

    cpu_acc(A_D, 32'hA5, 4'h1, 5, rd, w, ok, rc);
    chk("pre_wr_ok", {31'h0, ok}, 32'h1);
    cs_low;
    spi_bits(8'h3C, 8, got);
    chk("pre_miso", {24'h0, got}, 32'hA5);
    cs_high;
    cpu_acc(A_D, 0, 4'h0, 5, rd, w, ok, rc);
    chk("pre_rd", rd, 32'h3C);
    cpu_acc(A_S, 0, 4'h0, 5, rd, w, ok, rc);
    chk("pre_status", rd, 32'h0);

    fork
      begin
        cs_low;
        spi_bits(8'h55, 8, got);
        cs_high;
      end
      begin
        tick(2);
        cpu_acc(A_D, 0, 4'h0, 400, rd, w, ok, rc);
      end
    join
    chk("fill_miso", {24'h0, got}, 32'hFF);
    chk("stall_ok", {31'h0, ok}, 32'h1);
    chk("stall_rd", rd, 32'h55);
    chk("stall_waited", {31'h0, w > 20}, 32'h1);
    chk("stall_latency", rc - rise8, 32'd3);

    cs_low;
    spi_bits(8'h11, 8, got);
    spi_bits(8'h22, 8, got);
    cs_high;
    cpu_acc(A_S, 0, 4'h0, 5, rd, w, ok, rc);
    chk("ovr_status", rd, 32'h5);
    cpu_acc(A_D, 0, 4'h0, 5, rd, w, ok, rc);
    chk("ovr_rd", rd, 32'h22);
    cpu_acc(A_S, 32'h4, 4'h1, 5, rd, w, ok, rc);
    cpu_acc(A_S, 0, 4'h0, 5, rd, w, ok, rc);
    chk("ovr_clear", rd, 32'h0);

    cpu_acc(A_D, 32'h01, 4'h1, 5, rd, w, ok, rc);
    fork
      cpu_acc(A_D, 32'h02, 4'h1, 200, rd2, w2, ok2, rc);
      begin
        tick(20);
        spi_cs_n = 1'b0;
      end
    join
    chk("wr2_ok", {31'h0, ok2}, 32'h1);
    chk("wr2_stalled", {31'h0, w2 > 15}, 32'h1);
    cpu_acc(A_S, 0, 4'h0, 5, rd, w, ok, rc);
    chk("wr2_status", rd, 32'hA);
    spi_bits(8'h00, 8, got);
    chk("wr2_miso0", {24'h0, got}, 32'h01);
    spi_bits(8'h00, 8, got);
    chk("wr2_miso1", {24'h0, got}, 32'h02);
    cs_high;
    cpu_acc(A_D, 0, 4'h0, 5, rd, w, ok, rc);
    cpu_acc(A_S, 32'h4, 4'h1, 5, rd, w, ok, rc);

    cs_low;
    spi_bits(8'hFF, 5, got);
    cs_high;
    cpu_acc(A_S, 0, 4'h0, 5, rd, w, ok, rc);
    chk("part_status", rd, 32'h0);
    cs_low;
    spi_bits(8'h80, 8, got);
    cs_high;
    cpu_acc(A_D, 0, 4'h0, 5, rd, w, ok, rc);
    chk("realign_rd", rd, 32'h80);

    m_tx_full = 1'b0;
    m_has = 1'b0;
    m_ovr = 1'b0;
    m_tx = 8'h0;
    m_rx = 8'h0;
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(1) == 1) begin
        m_tx = 8'($urandom);
        cpu_acc(A_D, {24'h0, m_tx}, 4'h1, 5, rd, w, ok, rc);
        chk("rnd_wr_ok", {31'h0, ok}, 32'h1);
        m_tx_full = 1'b1;
      end
      nb = $urandom_range(3, 1);
      cs_low;
      for (int k = 0; k < nb; k++) begin
        d = 8'($urandom);
        exp_tx = (k == 0 && m_tx_full) ? m_tx : 8'hFF;
        spi_bits(d, 8, got);
        chk("rnd_miso", {24'h0, got}, {24'h0, exp_tx});
        if (m_has) m_ovr = 1'b1;
        m_rx = d;
        m_has = 1'b1;
      end
      m_tx_full = 1'b0;
      cs_high;
      cpu_acc(A_S, 0, 4'h0, 5, rd, w, ok, rc);
      chk("rnd_status", rd, {28'h0, 1'b0, m_ovr, m_tx_full, m_has});
      if ($urandom_range(1) == 1) begin
        cpu_acc(A_D, 0, 4'h0, 5, rd, w, ok, rc);
        chk("rnd_rd", rd, {24'h0, m_rx});
        m_has = 1'b0;
      end
      if ($urandom_range(2) == 0) begin
        cpu_acc(A_S, 32'h4, 4'h1, 5, rd, w, ok, rc);
        m_ovr = 1'b0;
      end
    end

    cpu_acc(A_D, 32'hA5, 4'h1, 5, rd, w, ok, rc);
    cs_low;
    chk("mid_miso", {31'h0, spi_miso}, 32'h1);
    spi_bits(8'h5A, 3, got);
    spi_sclk = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_miso", {31'h0, spi_miso}, 32'h0);
    chk("mid_rst_ready", {31'h0, spi_ready}, 32'h0);
    chk("mid_rst_rdata", spi_rdata, 32'h0);
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    tick(3);
    resetn = 1'b1;
    tick(3);
    cpu_acc(A_S, 0, 4'h0, 5, rd, w, ok, rc);
    chk("mid_rst_status", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
